// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops and a DATA_W-cycle radix-2
// shift-add multiplier, with a valid/ready handshake on both sides.
module multicycle_alu #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(DATA_W - 1);

  state_t              state_r;
  logic [SHAMT_W-1:0]  cnt_r;
  logic [DATA_W-1:0]   mcand_r;
  logic [DATA_W-1:0]   mplier_r;
  logic [DATA_W-1:0]   acc_r;
  logic [DATA_W-1:0]   result_s;
  logic [DATA_W-1:0]   step_acc_s;
  logic                accept_s;

  assign in_ready = (state_r == IDLE) && (!out_valid || out_ready);
  assign accept_s = in_valid && in_ready;
  assign busy     = (state_r == MUL_RUN);

  // Single-cycle result for every opcode except MUL; unused codes yield zero
  always_comb begin
    result_s = '0;
    case (alu_control)
      OP_AND:  result_s = alu_in_0 & alu_in_1;
      OP_OR:   result_s = alu_in_0 | alu_in_1;
      OP_ADD:  result_s = alu_in_0 + alu_in_1;
      OP_SLL:  result_s = alu_in_0 << alu_in_1[SHAMT_W-1:0];
      OP_SRL:  result_s = alu_in_0 >> alu_in_1[SHAMT_W-1:0];
      OP_SUB:  result_s = alu_in_0 - alu_in_1;
      OP_SLT:  result_s = {{(DATA_W-1){1'b0}}, ($signed(alu_in_0) < $signed(alu_in_1))};
      default: result_s = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    step_acc_s = acc_r;
    if (mplier_r[0]) begin
      step_acc_s = acc_r + mcand_r;
    end else begin
      step_acc_s = acc_r;
    end
  end

  // Control FSM together with the multiplier datapath and the result register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      mcand_r   <= '0;
      mplier_r  <= '0;
      acc_r     <= '0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      zero      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && (alu_control == OP_MUL)) begin
            mcand_r  <= alu_in_0;
            mplier_r <= alu_in_1;
            acc_r    <= '0;
            cnt_r    <= '0;
            state_r  <= MUL_RUN;
            if (out_ready) begin
              out_valid <= 1'b0;
            end
          end else if (accept_s) begin
            alu_out   <= result_s;
            zero      <= (result_s == '0);
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL_RUN: begin
          acc_r    <= step_acc_s;
          mcand_r  <= {mcand_r[DATA_W-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
          if (cnt_r == LAST_STEP) begin
            // Final step: step_acc_s already holds the low half of the product
            alu_out   <= step_acc_s;
            zero      <= (step_acc_s == '0);
            out_valid <= 1'b1;
            cnt_r     <= '0;
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_r + SHAMT_W'(1);
            if (out_ready) begin
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed corner cases plus a random op
// stream checked against a plain-arithmetic reference model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] alu_in_0;
  logic [31:0] alu_in_1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        zero;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit rand_ready = 1'b0;
  logic [31:0] sb[$];

  multicycle_alu #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the operation's meaning in plain integer arithmetic
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned prod;
    int sa;
    sa = int'(b % 32);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a << sa;
      4'd4: return a >> sa;
      4'd6: return a - b;
      4'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8: begin
        prod = longint'(a) * longint'(b);
        return prod[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom % 64;
      default: return $urandom;
    endcase
  endfunction

  // Present an op until accepted; on accept optionally push its expected result
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    int w = 0;
    in_valid = 1'b1; alu_control = op; alu_in_0 = a; alu_in_1 = b;
    @(negedge clk);
    while (!in_ready && w < 500) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", w);
    end else if (push) begin
      sb.push_back(exp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_control = 4'($urandom); alu_in_0 = $urandom; alu_in_1 = $urandom;
  endtask

  task automatic drain();
    int w = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && w < 200) begin
      w++;
      @(posedge clk);
    end
    #1;
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  // Random consumer backpressure when enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = (($urandom % 3) != 0);
    end
  end

  // Monitor: every consumed result must match the oldest outstanding expectation
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (arst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: got 0x%0h with no outstanding op", alu_out);
        end else begin
          e = sb.pop_front();
          check("result", 64'(alu_out), 64'(e));
          check("zero_flag", 64'(zero), 64'(e == 32'd0));
        end
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    arst_n = 1'b0; in_valid = 1'b0; alu_control = 4'd0;
    alu_in_0 = 32'd0; alu_in_1 = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_alu_out", 64'(alu_out), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // ADD wraps
    out_ready = 1'b1;
    issue(4'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
    check("add_wrap_valid", 64'(out_valid), 64'd1);
    check("add_wrap_out", 64'(alu_out), 64'd0);
    check("add_wrap_zero", 64'(zero), 64'd1);
    issue(4'd7, 32'hFFFFFFFE, 32'd3, 32'd1, 1'b1);
    check("slt_neg_out", 64'(alu_out), 64'd1);
    issue(4'd4, 32'h80000000, 32'h21, 32'h40000000, 1'b1);
    check("srl_mask_out", 64'(alu_out), 64'h40000000);
    issue(4'd5, 32'h12345678, 32'h9, 32'd0, 1'b1);
    issue(4'd15, 32'hDEADBEEF, 32'h1, 32'd0, 1'b1);
    drain();

    // MUL latency, busy and in_ready while iterating
    out_ready = 1'b0;
    issue(4'd8, 32'h00012345, 32'h00010000, 32'h23450000, 1'b1);
    for (int k = 0; k < 32; k++) begin
      check("mul_busy", 64'(busy), 64'd1);
      check("mul_in_ready", 64'(in_ready), 64'd0);
      check("mul_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check("mul_done_valid", 64'(out_valid), 64'd1);
    check("mul_done_busy", 64'(busy), 64'd0);
    check("mul_done_out", 64'(alu_out), 64'h23450000);
    drain();

    // Backpressure then back-to-back accept
    issue(4'd2, 32'd5, 32'd7, 32'd12, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = 4'd1; alu_in_0 = 32'hA0; alu_in_1 = 32'h05;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_out", 64'(alu_out), 64'd12);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    sb.push_back(32'hA5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_out", 64'(alu_out), 64'hA5);
    drain();

    // Reset in the middle of a multiply abandons it
    out_ready = 1'b0;
    issue(4'd8, 32'h1234, 32'h5678, 32'd0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    check("mid_mul_busy", 64'(busy), 64'd1);
    #2 arst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_out", 64'(alu_out), 64'd0);
    check("async_rst_zero", 64'(zero), 64'd1);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'd1, 32'hF0, 32'h0F, 32'hFF, 1'b1);
    check("post_rst_or", 64'(alu_out), 64'hFF);
    drain();

    // Random stream with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a = rnd_val();
      b = rnd_val();
      issue(op, a, b, ref_alu(op, a, b), 1'b1);
      repeat ($urandom % 3) begin @(posedge clk); #1; end
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    drain();
    repeat (3) begin @(posedge clk); #1; end
    check("final_no_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
